// File: rtl/io_link_pkg.sv
// Shared definitions for the host end of the CPU's 16-bit I/O port link.
// Holds bit positions, the re-alignment length and the handshake FSM encoding.
package io_link_pkg;

    localparam int DATA_LSB    = 0;
    localparam int DATA_MSB    = 7;
    localparam int REQ_BIT     = 8;
    localparam int CACK_BIT    = 9;
    localparam int HACK_BIT    = 8;
    localparam int HVLD_BIT    = 9;
    localparam int SYNC_CYCLES = 2;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        WAIT = 2'd2
    } link_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fill count; push/pop in the same cycle keeps the count unchanged.
// Latency: a pushed word appears at the head one cycle later (no bypass when empty).
// Backpressure: push while full and pop while empty are dropped without state change.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage is not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/io_host_link.sv
// Host end of the CPU I/O port link: toggle handshakes on IO64/IO65, byte FIFOs to a valid/ready host.
// Latency: IO64 change to HACK flip 2 cycles; TX FIFO head to IO65 1 cycle, 1 idle cycle between words.
// Backpressure: RX full withholds HACK so the CPU holds its byte; TX_READY drops when full or re-syncing.
module io_host_link
    import io_link_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [15:0]      IO64_OUT,
    output logic [15:0]      IO65_IN,
    output logic [7:0]       RX_DATA,
    output logic             RX_VALID,
    input  logic             RX_READY,
    input  logic [7:0]       TX_DATA,
    input  logic             TX_VALID,
    output logic             TX_READY,
    output logic [CNT_W-1:0] RX_COUNT,
    output logic [CNT_W-1:0] TX_COUNT
);

    link_state_t  state;
    link_state_t  state_nxt;
    logic [1:0]   sync_cnt;
    logic [9:0]   io64_q;
    logic         hack;
    logic         hvld;
    logic [7:0]   io65_dat;
    logic         rx_push;
    logic         rx_pop;
    logic         rx_full;
    logic         rx_empty;
    logic         tx_push;
    logic         tx_pop;
    logic         tx_full;
    logic         tx_empty;
    logic [7:0]   tx_dout;
    logic         io64_unused;

    assign io64_unused = ^IO64_OUT[15:10];

    assign rx_pop   = RX_READY && (state != SYNC);
    assign TX_READY = !tx_full && (state != SYNC);
    assign tx_push  = TX_VALID && TX_READY;
    assign RX_VALID = !rx_empty;
    assign IO65_IN  = {6'b0, hvld, hack, io65_dat};

    always_comb begin
        state_nxt = state;
        tx_pop    = 1'b0;
        // RX fullness is the pre-pop view, so a freed slot is used one cycle later.
        rx_push   = (state != SYNC) && (io64_q[REQ_BIT] != hack) && !rx_full;
        case (state)
            SYNC: if (sync_cnt == 2'(SYNC_CYCLES - 1)) state_nxt = IDLE;
            IDLE: begin
                if (!tx_empty) begin
                    tx_pop    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: if (io64_q[CACK_BIT] == hvld) state_nxt = IDLE;
            default: state_nxt = SYNC;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= SYNC;
            sync_cnt <= '0;
            io64_q   <= '0;
            hack     <= 1'b0;
            hvld     <= 1'b0;
            io65_dat <= '0;
        end else begin
            state  <= state_nxt;
            io64_q <= IO64_OUT[9:0];
            if (state == SYNC) begin
                sync_cnt <= sync_cnt + 2'd1;
                // Adopt whatever toggle phase the CPU is in; any half-done transfer is dropped.
                if (sync_cnt == 2'(SYNC_CYCLES - 1)) begin
                    hack <= io64_q[REQ_BIT];
                    hvld <= io64_q[CACK_BIT];
                end
            end
            if (rx_push) hack <= ~hack;
            if (tx_pop) begin
                io65_dat <= tx_dout;
                hvld     <= ~hvld;
            end
        end
    end

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(8), .CNT_W(CNT_W)) u_rx_fifo (
        .clk      (CLK),
        .rst      (RESET),
        .push     (rx_push),
        .push_dat (io64_q[DATA_MSB:DATA_LSB]),
        .pop      (rx_pop),
        .pop_dat  (RX_DATA),
        .count    (RX_COUNT),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(8), .CNT_W(CNT_W)) u_tx_fifo (
        .clk      (CLK),
        .rst      (RESET),
        .push     (tx_push),
        .push_dat (TX_DATA),
        .pop      (tx_pop),
        .pop_dat  (tx_dout),
        .count    (TX_COUNT),
        .full     (tx_full),
        .empty    (tx_empty)
    );

endmodule

// File: tb/tb_io_host_link.sv
// Directed bench for io_host_link: inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_io_host_link;

    logic        CLK;
    logic        RESET;
    logic [15:0] IO64_OUT;
    logic [15:0] IO65_IN;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        RX_READY;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY;
    logic [2:0]  RX_COUNT;
    logic [2:0]  TX_COUNT;

    int checks = 0;
    int errors = 0;

    io_host_link #(.DEPTH(4), .CNT_W(3)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .IO64_OUT (IO64_OUT),
        .IO65_IN  (IO65_IN),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .RX_READY (RX_READY),
        .TX_DATA  (TX_DATA),
        .TX_VALID (TX_VALID),
        .TX_READY (TX_READY),
        .RX_COUNT (RX_COUNT),
        .TX_COUNT (TX_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] cpu_dat;
        logic       cpu_req;
        logic       cpu_cack;
        logic       tx_fire;
        int         host_idx;
        int         rx_idx;
        int         cpu_sent;
        int         cpu_rcv;
        int         cyc;

        RESET    = 1'b1;
        IO64_OUT = 16'h0000;
        RX_READY = 1'b0;
        TX_DATA  = 8'h00;
        TX_VALID = 1'b0;
        tick(3);

        // Reset state
        chk("rst_io65", IO65_IN, 16'h0000);
        chk("rst_rx_valid", 16'(RX_VALID), 16'h0);
        chk("rst_tx_ready", 16'(TX_READY), 16'h0);
        chk("rst_rx_count", 16'(RX_COUNT), 16'h0);
        chk("rst_tx_count", 16'(TX_COUNT), 16'h0);
        RESET = 1'b0;
        chk("sync0_tx_ready", 16'(TX_READY), 16'h0);
        tick(1);
        chk("sync1_tx_ready", 16'(TX_READY), 16'h0);
        tick(1);
        chk("idle_tx_ready", 16'(TX_READY), 16'h1);

        // Single inbound byte: HACK two edges after IO64 changes
        IO64_OUT = 16'h01A5;
        tick(1);
        chk("rx1_early_io65", IO65_IN, 16'h0000);
        chk("rx1_early_valid", 16'(RX_VALID), 16'h0);
        tick(1);
        chk("rx1_io65", IO65_IN, 16'h0100);
        chk("rx1_valid", 16'(RX_VALID), 16'h1);
        chk("rx1_data", 16'(RX_DATA), 16'h00A5);
        chk("rx1_count", 16'(RX_COUNT), 16'h1);
        RX_READY = 1'b1;
        tick(1);
        RX_READY = 1'b0;
        chk("rx1_pop_valid", 16'(RX_VALID), 16'h0);
        chk("rx1_pop_count", 16'(RX_COUNT), 16'h0);

        // Fill RX with 4 bytes, 5th is held off until a slot frees
        IO64_OUT = 16'h0011; tick(2);
        chk("fill1_hack", IO65_IN, 16'h0000);
        IO64_OUT = 16'h0122; tick(2);
        chk("fill2_hack", IO65_IN, 16'h0100);
        IO64_OUT = 16'h0033; tick(2);
        chk("fill3_hack", IO65_IN, 16'h0000);
        IO64_OUT = 16'h0144; tick(2);
        chk("fill4_hack", IO65_IN, 16'h0100);
        chk("fill4_count", 16'(RX_COUNT), 16'h4);
        IO64_OUT = 16'h0055; tick(4);
        chk("full_hack_held", IO65_IN, 16'h0100);
        chk("full_count", 16'(RX_COUNT), 16'h4);
        chk("full_head", 16'(RX_DATA), 16'h0011);
        RX_READY = 1'b1;
        tick(1);
        RX_READY = 1'b0;
        chk("free_count", 16'(RX_COUNT), 16'h3);
        chk("free_hack_held", IO65_IN, 16'h0100);
        tick(1);
        chk("late_hack", IO65_IN, 16'h0000);
        chk("late_count", 16'(RX_COUNT), 16'h4);
        RX_READY = 1'b1;
        chk("drain_22", 16'(RX_DATA), 16'h0022); tick(1);
        chk("drain_33", 16'(RX_DATA), 16'h0033); tick(1);
        chk("drain_44", 16'(RX_DATA), 16'h0044); tick(1);
        chk("drain_55", 16'(RX_DATA), 16'h0055); tick(1);
        RX_READY = 1'b0;
        chk("drain_count", 16'(RX_COUNT), 16'h0);
        chk("drain_valid", 16'(RX_VALID), 16'h0);

        // Outbound: second word waits for CACK
        TX_VALID = 1'b1;
        TX_DATA  = 8'h3C;
        tick(1);
        chk("tx_push1_count", 16'(TX_COUNT), 16'h1);
        TX_DATA = 8'h7E;
        tick(1);
        TX_VALID = 1'b0;
        chk("tx_word1", IO65_IN, 16'h023C);
        chk("tx_word1_count", 16'(TX_COUNT), 16'h1);
        tick(3);
        chk("tx_word1_held", IO65_IN, 16'h023C);
        IO64_OUT = 16'h0255;
        tick(2);
        chk("tx_word1_idle", IO65_IN, 16'h023C);
        tick(1);
        chk("tx_word2", IO65_IN, 16'h007E);
        chk("tx_word2_count", 16'(TX_COUNT), 16'h0);
        IO64_OUT = 16'h0055;
        tick(3);
        chk("tx_word2_held", IO65_IN, 16'h007E);

        // Reset with both CPU toggles high: re-align, capture nothing
        RESET    = 1'b1;
        IO64_OUT = 16'h03AB;
        tick(2);
        chk("rst2_io65", IO65_IN, 16'h0000);
        RESET = 1'b0;
        tick(1);
        chk("rst2_sync_ready", 16'(TX_READY), 16'h0);
        tick(1);
        chk("rst2_align", IO65_IN, 16'h0300);
        chk("rst2_rx_count", 16'(RX_COUNT), 16'h0);
        tick(3);
        chk("rst2_no_capture", 16'(RX_COUNT), 16'h0);
        chk("rst2_stable", IO65_IN, 16'h0300);

        // Concurrent traffic in both directions
        cpu_dat  = 8'hAB;
        cpu_req  = 1'b1;
        cpu_cack = 1'b1;
        tx_fire  = 1'b0;
        host_idx = 0;
        rx_idx   = 0;
        cpu_sent = 0;
        cpu_rcv  = 0;
        cyc      = 0;
        RX_READY = 1'b1;
        while (cyc < 400 && !(cpu_rcv == 8 && rx_idx == 8 && cpu_sent == 8 && host_idx == 8)) begin
            if (tx_fire) host_idx++;
            if (IO65_IN[8] == cpu_req && cpu_sent < 8) begin
                cpu_dat = 8'(cpu_sent + 1);
                cpu_req = ~cpu_req;
                cpu_sent++;
            end
            if (IO65_IN[9] != cpu_cack) begin
                chk("cpu_rx_byte", 16'(IO65_IN[7:0]), 16'(8'hF1 + 8'(cpu_rcv)));
                cpu_rcv++;
                cpu_cack = IO65_IN[9];
            end
            IO64_OUT = {6'b0, cpu_cack, cpu_req, cpu_dat};
            if (RX_VALID) begin
                chk("host_rx_byte", 16'(RX_DATA), 16'(8'h01 + 8'(rx_idx)));
                rx_idx++;
            end
            TX_VALID = (host_idx < 8);
            TX_DATA  = 8'hF1 + 8'(host_idx);
            tx_fire  = TX_VALID && TX_READY;
            chk("io65_upper_zero", 16'(IO65_IN[15:10]), 16'h0);
            tick(1);
            cyc++;
        end
        RX_READY = 1'b0;
        TX_VALID = 1'b0;
        chk("cpu_rx_total", 16'(cpu_rcv), 16'd8);
        chk("host_rx_total", 16'(rx_idx), 16'd8);
        chk("host_tx_total", 16'(host_idx), 16'd8);
        tick(4);
        chk("end_rx_count", 16'(RX_COUNT), 16'h0);
        chk("end_tx_count", 16'(TX_COUNT), 16'h0);
        chk("end_hack", 16'(IO65_IN[8]), 16'(cpu_req));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
